// File: rtl/arbitro_rr_4to1_if.sv
// Lane-side bundle of the 4:1 round-robin merger: four FIFO heads in, one egress FIFO out.
// The master modport is the arbiter; the slave modport is whoever owns the FIFOs.
interface arbitro_rr_4to1_if #(
  parameter int BW = 6
);
  logic          empty0, empty1, empty2, empty3;
  logic [BW-1:0] data_in0, data_in1, data_in2, data_in3;
  logic          pop0, pop1, pop2, pop3;
  logic          almost_full;
  logic          push;
  logic [BW-1:0] data_out;
  logic [3:0]    grant;
  logic          idle;

  // Handshake: pop_k is a same-cycle pop of the head word of lane k (taken only while !empty_k);
  // push is the registered write strobe, data_out is valid only while push=1, and almost_full
  // guarantees at least one free slot, absorbing the single in-flight push.
  modport master (
    input  empty0, empty1, empty2, empty3,
    input  data_in0, data_in1, data_in2, data_in3,
    input  almost_full,
    output pop0, pop1, pop2, pop3,
    output push, data_out, grant, idle
  );

  modport slave (
    output empty0, empty1, empty2, empty3,
    output data_in0, data_in1, data_in2, data_in3,
    output almost_full,
    input  pop0, pop1, pop2, pop3,
    input  push, data_out, grant, idle
  );
endinterface

// File: rtl/arbitro_rr_4to1.sv
// Round-robin arbiter merging four first-word-fall-through lane FIFOs into one egress FIFO,
// with bounded bursts per owner and almost_full backpressure.
module arbitro_rr_4to1 #(
  parameter int BW        = 6,
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           state,
  arbitro_rr_4to1_if.master    bus,
  output logic                 dbg_burst,
  output logic [1:0]           dbg_ptr,
  output logic [CNT_W-1:0]     dbg_cnt
);

  typedef enum logic {ARB_IDLE = 1'b0, ARB_BURST = 1'b1} arb_state_t;

  localparam logic [3:0] ST_RESET  = 4'b0001;
  localparam logic [3:0] ST_IDLE   = 4'b0100;
  localparam logic [3:0] ST_ACTIVE = 4'b1000;

  arb_state_t       fsm;
  logic [1:0]       ptr;
  logic [CNT_W-1:0] cnt;

  logic [3:0]       req;
  logic [BW-1:0]    din [4];
  logic             en;
  logic             any_req;
  logic             keep;
  logic             found;
  logic [1:0]       cand;
  logic [1:0]       sel;
  logic             pop_sel;
  logic             sync_rst;

  assign req     = {~bus.empty3, ~bus.empty2, ~bus.empty1, ~bus.empty0};
  assign din[0]  = bus.data_in0;
  assign din[1]  = bus.data_in1;
  assign din[2]  = bus.data_in2;
  assign din[3]  = bus.data_in3;
  assign any_req = |req;
  assign en      = ((state == ST_IDLE) || (state == ST_ACTIVE)) && !reset;
  assign sync_rst = reset || (state == ST_RESET);

  // The owner keeps the grant only while it still has data and burst budget left.
  assign keep = (fsm == ARB_BURST) && req[ptr] && (cnt < CNT_W'(MAX_BURST));

  always_comb begin
    sel   = ptr;
    found = 1'b0;
    cand  = ptr;
    if (!keep) begin
      // Search ptr+1, ptr+2, ptr+3, then ptr itself (i=4 wraps back to ptr).
      for (int i = 1; i <= 4; i++) begin
        cand = ptr + 2'(i);
        if (!found && req[cand]) begin
          sel   = cand;
          found = 1'b1;
        end
      end
    end
  end

  assign pop_sel  = en && !bus.almost_full && any_req;
  assign bus.pop0 = pop_sel && (sel == 2'd0);
  assign bus.pop1 = pop_sel && (sel == 2'd1);
  assign bus.pop2 = pop_sel && (sel == 2'd2);
  assign bus.pop3 = pop_sel && (sel == 2'd3);

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      fsm          <= ARB_IDLE;
      ptr          <= 2'd3;
      cnt          <= '0;
      bus.push     <= 1'b0;
      bus.data_out <= '0;
      bus.grant    <= 4'b0000;
      bus.idle     <= 1'b1;
    end else if (pop_sel) begin
      fsm          <= ARB_BURST;
      ptr          <= sel;
      // A re-grant to an exhausted owner restarts the burst instead of counting past the limit.
      cnt          <= keep ? cnt + CNT_W'(1) : CNT_W'(1);
      bus.push     <= 1'b1;
      bus.data_out <= din[sel];
      bus.grant    <= 4'b0001 << sel;
      bus.idle     <= 1'b0;
    end else begin
      bus.push  <= 1'b0;
      bus.grant <= 4'b0000;
      bus.idle  <= !any_req;
      if (en && !any_req) begin
        fsm <= ARB_IDLE;
      end
    end
  end

  assign dbg_burst = (fsm == ARB_BURST);
  assign dbg_ptr   = ptr;
  assign dbg_cnt   = cnt;

endmodule
